kart_motion: RTL and testbench

// - Per-frame kart kinematics: turns driver inputs into player_x/player_y/direction.
// - Output feeds the player_x/player_y/direction inputs of the track and racer viewers,

---
 rtl/kart_motion.sv | 203 ++++++++++++++++++++
 tb/tb_kart_motion.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kart_motion.sv
// kart_motion: per-frame kart kinematics producing heading, signed speed and 11.4 fixed-point position.
// Optional feature macro KART_REVERSE_EN lets braking drive the kart backwards down to -MAX_SPEED/2.
module kart_motion #(
  parameter int START_X     = 191,
  parameter int START_Y     = 191,
  parameter int START_DIR   = 270,
  parameter int MAP_SIZE    = 512,
  parameter int ACCEL       = 2,
  parameter int BRAKE       = 4,
  parameter int DECEL       = 1,
  parameter int MAX_SPEED   = 32,
  parameter int OFFROAD_MAX = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              frame_tick_in,
  input  logic              accel_in,
  input  logic              brake_in,
  input  logic              left_in,
  input  logic              right_in,
  input  logic              offroad_in,
  output logic [10:0]       player_x,
  output logic [10:0]       player_y,
  output logic [8:0]        direction,
  output logic signed [7:0] speed_out,
  output logic              update_done,
  output logic              overrun_out
);

  typedef enum logic [2:0] {IDLE, STEER, SPEED, MULT, MOVE, DONE} state_t;

  localparam logic [4:0]         START_IDX = 5'(START_DIR / 15);
  localparam logic [14:0]        START_PX  = 15'(START_X * 16);
  localparam logic [14:0]        START_PY  = 15'(START_Y * 16);
  localparam logic signed [15:0] POS_MAX   = 16'(MAP_SIZE * 16 - 1);
  localparam logic signed [9:0]  ACCEL_S   = 10'(ACCEL);
  localparam logic signed [9:0]  BRAKE_S   = 10'(BRAKE);
  localparam logic signed [9:0]  DECEL_S   = 10'(DECEL);
  localparam logic signed [9:0]  MAX_S     = 10'(MAX_SPEED);
  localparam logic signed [9:0]  OFF_S     = 10'(OFFROAD_MAX);
`ifdef KART_REVERSE_EN
  localparam logic signed [9:0]  FLOOR_S   = 10'(-(MAX_SPEED / 2));
`else
  localparam logic signed [9:0]  FLOOR_S   = 10'sd0;
`endif

  state_t             state, state_next;
  logic [4:0]         idx, idx_next;
  logic signed [7:0]  speed, speed_next;
  logic [14:0]        pos_x, pos_x_next, pos_y, pos_y_next;
  logic signed [15:0] dx, dx_next, dy, dy_next;
  logic signed [9:0]  spd_calc, spd_cap;
  logic signed [15:0] prod_x, prod_y, sum_x, sum_y;
  logic signed [7:0]  cos_val, sin_val;
  logic [4:0]         sin_idx;
  logic               load_out, hit;

  // Q1.7 cosine of index*15 degrees; sine reuses it shifted by a quarter turn.
  function automatic logic signed [7:0] cos_lut(input logic [4:0] k);
    case (k)
      5'd0:    cos_lut = 8'sd127;
      5'd1:    cos_lut = 8'sd123;
      5'd2:    cos_lut = 8'sd110;
      5'd3:    cos_lut = 8'sd90;
      5'd4:    cos_lut = 8'sd64;
      5'd5:    cos_lut = 8'sd33;
      5'd6:    cos_lut = 8'sd0;
      5'd7:    cos_lut = -8'sd33;
      5'd8:    cos_lut = -8'sd64;
      5'd9:    cos_lut = -8'sd90;
      5'd10:   cos_lut = -8'sd110;
      5'd11:   cos_lut = -8'sd123;
      5'd12:   cos_lut = -8'sd127;
      5'd13:   cos_lut = -8'sd123;
      5'd14:   cos_lut = -8'sd110;
      5'd15:   cos_lut = -8'sd90;
      5'd16:   cos_lut = -8'sd64;
      5'd17:   cos_lut = -8'sd33;
      5'd18:   cos_lut = 8'sd0;
      5'd19:   cos_lut = 8'sd33;
      5'd20:   cos_lut = 8'sd64;
      5'd21:   cos_lut = 8'sd90;
      5'd22:   cos_lut = 8'sd110;
      5'd23:   cos_lut = 8'sd123;
      default: cos_lut = 8'sd0;
    endcase
  endfunction

  assign sin_idx = (idx >= 5'd6) ? idx - 5'd6 : idx + 5'd18;
  assign cos_val = cos_lut(idx);
  assign sin_val = cos_lut(sin_idx);
  assign prod_x  = 16'(speed) * 16'(cos_val);
  assign prod_y  = 16'(speed) * 16'(sin_val);
  assign sum_x   = $signed({1'b0, pos_x}) + dx;
  assign sum_y   = $signed({1'b0, pos_y}) + dy;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    speed_next  = speed;
    pos_x_next  = pos_x;
    pos_y_next  = pos_y;
    dx_next     = dx;
    dy_next     = dy;
    spd_calc    = 10'(speed);
    spd_cap     = offroad_in ? OFF_S : MAX_S;
    hit         = 1'b0;
    load_out    = 1'b0;
    update_done = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick_in) state_next = STEER;
      end
      STEER: begin
        state_next = SPEED;
        if (left_in && !right_in)      idx_next = (idx == 5'd0)  ? 5'd23 : idx - 5'd1;
        else if (right_in && !left_in) idx_next = (idx == 5'd23) ? 5'd0  : idx + 5'd1;
      end
      SPEED: begin
        state_next = MULT;
        if (brake_in)                spd_calc = spd_calc - BRAKE_S;
        else if (accel_in)           spd_calc = spd_calc + ACCEL_S;
        else if (spd_calc > DECEL_S)  spd_calc = spd_calc - DECEL_S;
        else if (spd_calc < -DECEL_S) spd_calc = spd_calc + DECEL_S;
        else                         spd_calc = '0;
        if (spd_calc > spd_cap)      spd_calc = spd_cap;
        else if (spd_calc < FLOOR_S) spd_calc = FLOOR_S;
        speed_next = spd_calc[7:0];
      end
      MULT: begin
        state_next = MOVE;
        dx_next    = prod_x >>> 7;
        dy_next    = prod_y >>> 7;
      end
      MOVE: begin
        // Hitting either map edge pins that axis and stops the kart dead.
        state_next = DONE;
        load_out   = 1'b1;
        if (sum_x < 0) begin
          pos_x_next = '0;
          hit        = 1'b1;
        end else if (sum_x > POS_MAX) begin
          pos_x_next = POS_MAX[14:0];
          hit        = 1'b1;
        end else begin
          pos_x_next = sum_x[14:0];
        end
        if (sum_y < 0) begin
          pos_y_next = '0;
          hit        = 1'b1;
        end else if (sum_y > POS_MAX) begin
          pos_y_next = POS_MAX[14:0];
          hit        = 1'b1;
        end else begin
          pos_y_next = sum_y[14:0];
        end
        if (hit) speed_next = '0;
      end
      DONE: begin
        state_next  = IDLE;
        update_done = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Visible outputs load only on the MOVE->DONE edge so a frame never sees a half update.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx         <= START_IDX;
      speed       <= '0;
      pos_x       <= START_PX;
      pos_y       <= START_PY;
      dx          <= '0;
      dy          <= '0;
      player_x    <= 11'(START_X);
      player_y    <= 11'(START_Y);
      direction   <= 9'(START_DIR);
      speed_out   <= '0;
      overrun_out <= 1'b0;
    end else begin
      idx   <= idx_next;
      speed <= speed_next;
      pos_x <= pos_x_next;
      pos_y <= pos_y_next;
      dx    <= dx_next;
      dy    <= dy_next;
      if (load_out) begin
        player_x  <= pos_x_next[14:4];
        player_y  <= pos_y_next[14:4];
        direction <= 9'(idx) * 9'd15;
        speed_out <= speed_next;
      end
      if (frame_tick_in && state != IDLE) overrun_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kart_motion.sv
// tb_kart_motion: three parameterisations of kart_motion driven in lockstep and checked every
// cycle against a trigonometric per-frame model, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_kart_motion;

  localparam int N = 3;
`ifdef KART_REVERSE_EN
  localparam int SPEED_FLOOR = -16;
`else
  localparam int SPEED_FLOOR = 0;
`endif

  logic clk_in = 1'b0;
  logic rst_in, frame_tick_in, accel_in, brake_in, left_in, right_in, offroad_in;
  logic [10:0]       px   [N];
  logic [10:0]       py   [N];
  logic [8:0]        dir  [N];
  logic signed [7:0] spd  [N];
  logic              done [N];
  logic              ovr  [N];

  int assertions = 0;
  int failures   = 0;

  int start_x   [N] = '{191, 191, 2};
  int start_dir [N] = '{270, 0, 180};
  int m_x [N], m_y [N], m_dir [N], m_spd [N];
  int p_px [N], p_py [N], p_dir [N], p_spd [N];
  int e_px [N], e_py [N], e_dir [N], e_spd [N];
  int phase = 0;
  bit m_ovr = 1'b0;
  bit model_ready = 1'b0;

  always #5 clk_in = ~clk_in;

  kart_motion u_default (
    .clk_in(clk_in), .rst_in(rst_in), .frame_tick_in(frame_tick_in),
    .accel_in(accel_in), .brake_in(brake_in), .left_in(left_in), .right_in(right_in),
    .offroad_in(offroad_in), .player_x(px[0]), .player_y(py[0]), .direction(dir[0]),
    .speed_out(spd[0]), .update_done(done[0]), .overrun_out(ovr[0]));

  kart_motion #(.START_DIR(0)) u_wrap (
    .clk_in(clk_in), .rst_in(rst_in), .frame_tick_in(frame_tick_in),
    .accel_in(accel_in), .brake_in(brake_in), .left_in(left_in), .right_in(right_in),
    .offroad_in(offroad_in), .player_x(px[1]), .player_y(py[1]), .direction(dir[1]),
    .speed_out(spd[1]), .update_done(done[1]), .overrun_out(ovr[1]));

  kart_motion #(.START_X(2), .START_DIR(180)) u_wall (
    .clk_in(clk_in), .rst_in(rst_in), .frame_tick_in(frame_tick_in),
    .accel_in(accel_in), .brake_in(brake_in), .left_in(left_in), .right_in(right_in),
    .offroad_in(offroad_in), .player_x(px[2]), .player_y(py[2]), .direction(dir[2]),
    .speed_out(spd[2]), .update_done(done[2]), .overrun_out(ovr[2]));

  task automatic check_output(input string name, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Nearest-integer 127*cos(deg), with a tiny bias so exact halves round away from zero.
  function automatic int trig127(input int deg);
    real r;
    r = 127.0 * $cos(real'(deg) * 3.14159265358979323846 / 180.0);
    if (r >= 0.0) return int'($floor(r + 0.5 + 1.0e-9));
    else          return -int'($floor(-r + 0.5 + 1.0e-9));
  endfunction

  task automatic model_frame(input int i);
    int s, cap, dx, dy, nx, ny;
    bit hit;
    if (left_in && !right_in)      m_dir[i] = (m_dir[i] + 345) % 360;
    else if (right_in && !left_in) m_dir[i] = (m_dir[i] + 15) % 360;
    s = m_spd[i];
    if (brake_in)      s = s - 4;
    else if (accel_in) s = s + 2;
    else if (s > 0)    s = (s > 1) ? s - 1 : 0;
    else if (s < 0)    s = (s < -1) ? s + 1 : 0;
    cap = offroad_in ? 16 : 32;
    if (s > cap)         s = cap;
    if (s < SPEED_FLOOR) s = SPEED_FLOOR;
    dx = int'($floor(real'(s * trig127(m_dir[i])) / 128.0));
    dy = int'($floor(real'(s * trig127(m_dir[i] + 270)) / 128.0));
    nx = m_x[i] + dx;
    ny = m_y[i] + dy;
    hit = 1'b0;
    if (nx < 0)    begin nx = 0;    hit = 1'b1; end
    if (nx > 8191) begin nx = 8191; hit = 1'b1; end
    if (ny < 0)    begin ny = 0;    hit = 1'b1; end
    if (ny > 8191) begin ny = 8191; hit = 1'b1; end
    if (hit) s = 0;
    m_x[i] = nx;
    m_y[i] = ny;
    m_spd[i] = s;
    p_px[i] = nx / 16;
    p_py[i] = ny / 16;
    p_dir[i] = m_dir[i];
    p_spd[i] = s;
  endtask

  // Model: a frame is computed when the tick is accepted; results become visible 5 cycles later.
  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) begin
        m_x[i] = start_x[i] * 16;
        m_y[i] = 191 * 16;
        m_dir[i] = start_dir[i];
        m_spd[i] = 0;
        e_px[i] = start_x[i];
        e_py[i] = 191;
        e_dir[i] = start_dir[i];
        e_spd[i] = 0;
      end
      phase = 0;
      m_ovr = 1'b0;
      model_ready = 1'b1;
    end else if (phase != 0) begin
      if (frame_tick_in) m_ovr = 1'b1;
      phase = (phase == 5) ? 0 : phase + 1;
      if (phase == 5) begin
        for (int i = 0; i < N; i++) begin
          e_px[i] = p_px[i];
          e_py[i] = p_py[i];
          e_dir[i] = p_dir[i];
          e_spd[i] = p_spd[i];
        end
      end
    end else if (frame_tick_in) begin
      for (int i = 0; i < N; i++) model_frame(i);
      phase = 1;
    end
  end

  always @(negedge clk_in) begin
    if (model_ready) begin
      for (int i = 0; i < N; i++) begin
        check_output($sformatf("u%0d.player_x", i), int'(px[i]), e_px[i]);
        check_output($sformatf("u%0d.player_y", i), int'(py[i]), e_py[i]);
        check_output($sformatf("u%0d.direction", i), int'(dir[i]), e_dir[i]);
        check_output($sformatf("u%0d.speed_out", i), int'(spd[i]), e_spd[i]);
        check_output($sformatf("u%0d.update_done", i), int'(done[i]), int'(phase == 5));
        check_output($sformatf("u%0d.overrun_out", i), int'(ovr[i]), int'(m_ovr));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    {accel_in, brake_in, left_in, right_in, offroad_in, frame_tick_in} = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic apply_stimulus(input bit a, input bit b, input bit l, input bit r, input bit o);
    int waited;
    @(negedge clk_in);
    accel_in = a;
    brake_in = b;
    left_in = l;
    right_in = r;
    offroad_in = o;
    frame_tick_in = 1'b1;
    @(negedge clk_in);
    frame_tick_in = 1'b0;
    waited = 0;
    while (!done[0] && waited < 20) begin
      @(negedge clk_in);
      waited++;
    end
    check_output("update_done_arrives", int'(waited < 20), 1);
    @(negedge clk_in);
  endtask

  int accel_spd [4] = '{2, 4, 6, 8};
  int accel_py  [4] = '{190, 190, 190, 189};
  int done_cnt;

  initial begin
    rst_in = 1'b1;
    {accel_in, brake_in, left_in, right_in, offroad_in, frame_tick_in} = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    check_output("reset player_x", int'(px[0]), 191);
    check_output("reset player_y", int'(py[0]), 191);
    check_output("reset direction", int'(dir[0]), 270);
    check_output("reset speed_out", int'(spd[0]), 0);
    check_output("reset update_done", int'(done[0]), 0);
    check_output("reset overrun_out", int'(ovr[0]), 0);

    for (int f = 1; f <= 6; f++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (f <= 4) begin
        check_output($sformatf("accel speed f%0d", f), int'(spd[0]), accel_spd[f-1]);
        check_output($sformatf("accel player_y f%0d", f), int'(py[0]), accel_py[f-1]);
        check_output($sformatf("accel player_x f%0d", f), int'(px[0]), 191);
      end
      if (f == 5) begin
        check_output("wall player_x f5", int'(px[2]), 0);
        check_output("wall speed f5", int'(spd[2]), 10);
      end
    end
    check_output("wall player_x f6", int'(px[2]), 0);
    check_output("wall speed f6", int'(spd[2]), 0);

    do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_output("left direction", int'(dir[0]), 255);
    check_output("left speed", int'(spd[0]), 0);
    check_output("left wrap direction", int'(dir[1]), 345);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_output("right direction", int'(dir[0]), 270);
    check_output("right wrap direction", int'(dir[1]), 0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_output("both steer direction", int'(dir[0]), 270);

    do_reset();
    repeat (17) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("top speed", int'(spd[0]), 32);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_output("offroad cap", int'(spd[0]), 16);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("coast 1", int'(spd[0]), 15);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("coast 2", int'(spd[0]), 14);

    do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("pre-brake speed", int'(spd[0]), 4);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("brake wins", int'(spd[0]), 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef KART_REVERSE_EN
    check_output("brake at rest", int'(spd[0]), -4);
    repeat (4) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_output("reverse floor", int'(spd[0]), -16);
`else
    check_output("brake at rest", int'(spd[0]), 0);
`endif

    do_reset();
    @(negedge clk_in);
    accel_in = 1'b1;
    frame_tick_in = 1'b1;
    @(negedge clk_in);
    frame_tick_in = 1'b0;
    @(negedge clk_in);
    frame_tick_in = 1'b1;
    @(negedge clk_in);
    frame_tick_in = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk_in);
      if (done[0]) done_cnt++;
    end
    check_output("overrun done count", done_cnt, 1);
    check_output("overrun set", int'(ovr[0]), 1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("overrun sticky", int'(ovr[0]), 1);
    do_reset();
    check_output("overrun cleared", int'(ovr[0]), 0);

    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check_output("pre-abort speed", int'(spd[0]), 2);
    @(negedge clk_in);
    frame_tick_in = 1'b1;
    @(negedge clk_in);
    frame_tick_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    done_cnt = 0;
    repeat (10) begin
      @(negedge clk_in);
      if (done[0]) done_cnt++;
    end
    check_output("abort done count", done_cnt, 0);
    check_output("abort player_x", int'(px[0]), 191);
    check_output("abort player_y", int'(py[0]), 191);
    check_output("abort direction", int'(dir[0]), 270);
    check_output("abort speed", int'(spd[0]), 0);

    repeat (2) @(negedge clk_in);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
